// File: rtl/mem_responder.sv
// Unified instruction/data memory with a valid/ready request, a one-cycle response pulse
// and programmable wait states. Bad accesses report rsp_err and never modify the array.
module mem_responder #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_adr,
  input  logic [31:0]       req_wdata,
  output logic              req_ready,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam int unsigned IdxW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StWait = 2'd1;
  localparam logic [1:0] StResp = 2'd2;

  localparam logic [3:0]        WaitInit   = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);
  localparam logic [ADDR_W-3:0] DepthLimit = (ADDR_W - 2)'(DEPTH_WORDS);

  logic [1:0]        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] adr_q;
  logic [31:0]       wdata_q;
  logic              write_q;
  logic              rsp_valid_q;
  logic [31:0]       rdata_q;
  logic              err_q;

  logic [31:0] mem [DEPTH_WORDS];

  logic              accept;
  logic              enter_resp;
  logic [ADDR_W-1:0] acc_adr;
  logic [31:0]       acc_wdata;
  logic              acc_write;
  logic              acc_err;
  logic [IdxW-1:0]   acc_idx;

  assign req_ready = reset & (state_q == StIdle);
  assign accept    = req_valid & req_ready;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

  // With zero wait states the access happens on the accept edge, so use the live request.
  assign acc_adr   = (state_q == StIdle) ? req_adr   : adr_q;
  assign acc_wdata = (state_q == StIdle) ? req_wdata : wdata_q;
  assign acc_write = (state_q == StIdle) ? req_write : write_q;

  // High address bits take part in the range check, so there is no wrap-around.
  assign acc_err = (acc_adr[1:0] != 2'b00) | (acc_adr[ADDR_W-1:2] >= DepthLimit);
  assign acc_idx = acc_adr[IdxW+1:2];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    enter_resp = 1'b0;
    case (state_q)
      StIdle: begin
        if (req_valid) begin
          if (WAIT_CYCLES == 0) begin
            state_d    = StResp;
            enter_resp = 1'b1;
          end else begin
            state_d = StWait;
            cnt_d   = WaitInit;
          end
        end
      end
      StWait: begin
        if (cnt_q == 4'd0) begin
          state_d    = StResp;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= StIdle;
      cnt_q       <= 4'd0;
      adr_q       <= '0;
      wdata_q     <= 32'd0;
      write_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= 32'd0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= enter_resp;
      if (accept) begin
        adr_q   <= req_adr;
        wdata_q <= req_wdata;
        write_q <= req_write;
      end
      if (enter_resp) begin
        err_q   <= acc_err;
        rdata_q <= (acc_write | acc_err) ? 32'd0 : mem[acc_idx];
      end
    end
  end

  // Array is not reset; a reset edge suppresses any pending write.
  always_ff @(posedge clk) begin
    if (reset && enter_resp && acc_write && !acc_err) begin
      mem[acc_idx] <= acc_wdata;
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: one instance with two wait states, one with none.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        reset;

  logic        v2, w2, rdy2, rv2, re2;
  logic [31:0] a2, d2, rd2;
  logic        v0, w0, rdy0, rv0, re0;
  logic [31:0] a0, d0, rd0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_responder #(.ADDR_W(32), .DEPTH_WORDS(64), .WAIT_CYCLES(2)) dut2 (
    .clk(clk), .reset(reset), .req_valid(v2), .req_write(w2), .req_adr(a2), .req_wdata(d2),
    .req_ready(rdy2), .rsp_valid(rv2), .rsp_rdata(rd2), .rsp_err(re2)
  );

  mem_responder #(.ADDR_W(32), .DEPTH_WORDS(64), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .req_valid(v0), .req_write(w0), .req_adr(a0), .req_wdata(d0),
    .req_ready(rdy0), .rsp_valid(rv0), .rsp_rdata(rd0), .rsp_err(re0)
  );

  // One transaction on dut2; lat counts edges from accept to the rsp_valid sample (0 = timeout).
  task automatic do_req2(input logic wr, input logic [31:0] adr, input logic [31:0] wd,
                         output int lat, output logic [31:0] rdata, output logic err);
    @(posedge clk); #1;
    v2 = 1'b1; w2 = wr; a2 = adr; d2 = wd;
    @(posedge clk); #1;
    v2 = 1'b0;
    lat = 1;
    while (!rv2 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!rv2) lat = 0;
    rdata = rd2;
    err   = re2;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    v2 = 1'b0; w2 = 1'b0; a2 = 32'd0; d2 = 32'd0;
    v0 = 1'b0; w0 = 1'b0; a0 = 32'd0; d0 = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    n_tests++; if (rdy2 !== 1'b0) begin n_fail++; $display("FAIL reset_ready got=%b exp=0", rdy2); end
    n_tests++; if (rv2 !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", rv2); end
    n_tests++; if (rd2 !== 32'd0) begin n_fail++; $display("FAIL reset_rdata got=%h exp=0", rd2); end
    n_tests++; if (re2 !== 1'b0) begin n_fail++; $display("FAIL reset_err got=%b exp=0", re2); end
    reset = 1'b1;
    @(posedge clk); #1;
    n_tests++; if (rdy2 !== 1'b1) begin n_fail++; $display("FAIL idle_ready got=%b exp=1", rdy2); end
    n_tests++; if (rdy0 !== 1'b1) begin n_fail++; $display("FAIL idle_ready0 got=%b exp=1", rdy0); end
  endtask

  task automatic test_write_read();
    int lat; logic [31:0] rd; logic er;
    do_req2(1'b1, 32'h10, 32'hDEADBEEF, lat, rd, er);
    n_tests++; if (lat !== 3) begin n_fail++; $display("FAIL wr_latency got=%0d exp=3", lat); end
    n_tests++; if (er !== 1'b0) begin n_fail++; $display("FAIL wr_err got=%b exp=0", er); end
    n_tests++; if (rd !== 32'd0) begin n_fail++; $display("FAIL wr_rdata got=%h exp=0", rd); end
    n_tests++; if (rdy2 !== 1'b0) begin n_fail++; $display("FAIL resp_ready got=%b exp=0", rdy2); end
    do_req2(1'b0, 32'h10, 32'h0, lat, rd, er);
    n_tests++; if (lat !== 3) begin n_fail++; $display("FAIL rd_latency got=%0d exp=3", lat); end
    n_tests++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rd_data got=%h exp=deadbeef", rd); end
    n_tests++; if (er !== 1'b0) begin n_fail++; $display("FAIL rd_err got=%b exp=0", er); end
    @(posedge clk); #1;
    n_tests++; if (rv2 !== 1'b0) begin n_fail++; $display("FAIL pulse_width got=%b exp=0", rv2); end
    n_tests++; if (rd2 !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rdata_hold got=%h exp=deadbeef", rd2); end
  endtask

  task automatic test_back_to_back();
    int pulses = 0;
    @(posedge clk); #1;
    v0 = 1'b1; w0 = 1'b1; a0 = 32'h4; d0 = 32'h0000_1111;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (rv0) pulses++;
      n_tests++;
      if (rv0 !== ((i % 2) == 0)) begin
        n_fail++; $display("FAIL b2b_valid cycle=%0d got=%b exp=%b", i, rv0, (i % 2) == 0);
      end
      n_tests++;
      if (rdy0 !== ((i % 2) == 1)) begin
        n_fail++; $display("FAIL b2b_ready cycle=%0d got=%b exp=%b", i, rdy0, (i % 2) == 1);
      end
    end
    n_tests++; if (pulses != 3) begin n_fail++; $display("FAIL b2b_pulses got=%0d exp=3", pulses); end
    // Last cycle of the loop was IDLE, so the next edge accepts the read.
    w0 = 1'b0;
    @(posedge clk); #1;
    v0 = 1'b0;
    n_tests++; if (rv0 !== 1'b1) begin n_fail++; $display("FAIL b2b_rd_valid got=%b exp=1", rv0); end
    n_tests++; if (rd0 !== 32'h0000_1111) begin n_fail++; $display("FAIL b2b_rd_data got=%h exp=00001111", rd0); end
  endtask

  task automatic test_range();
    int lat; logic [31:0] rd; logic er;
    do_req2(1'b1, 32'hFC, 32'hA5A5_0001, lat, rd, er);
    n_tests++; if (er !== 1'b0) begin n_fail++; $display("FAIL last_wr_err got=%b exp=0", er); end
    do_req2(1'b0, 32'hFC, 32'h0, lat, rd, er);
    n_tests++; if (er !== 1'b0) begin n_fail++; $display("FAIL last_rd_err got=%b exp=0", er); end
    n_tests++; if (rd !== 32'hA5A5_0001) begin n_fail++; $display("FAIL last_rd_data got=%h exp=a5a50001", rd); end
    do_req2(1'b0, 32'h100, 32'h0, lat, rd, er);
    n_tests++; if (er !== 1'b1) begin n_fail++; $display("FAIL oor_rd_err got=%b exp=1", er); end
    n_tests++; if (rd !== 32'd0) begin n_fail++; $display("FAIL oor_rd_data got=%h exp=0", rd); end
    do_req2(1'b1, 32'h100, 32'hFFFF_FFFF, lat, rd, er);
    n_tests++; if (er !== 1'b1) begin n_fail++; $display("FAIL oor_wr_err got=%b exp=1", er); end
    do_req2(1'b1, 32'h8000_00FC, 32'h0BAD_BAD0, lat, rd, er);
    n_tests++; if (er !== 1'b1) begin n_fail++; $display("FAIL high_wr_err got=%b exp=1", er); end
    do_req2(1'b0, 32'hFC, 32'h0, lat, rd, er);
    n_tests++; if (rd !== 32'hA5A5_0001) begin n_fail++; $display("FAIL oor_no_corrupt got=%h exp=a5a50001", rd); end
  endtask

  task automatic test_misaligned();
    int lat; logic [31:0] rd; logic er;
    do_req2(1'b1, 32'h20, 32'h0BAD_0020, lat, rd, er);
    do_req2(1'b1, 32'h22, 32'h1234_5678, lat, rd, er);
    n_tests++; if (er !== 1'b1) begin n_fail++; $display("FAIL mis_wr_err got=%b exp=1", er); end
    do_req2(1'b0, 32'h21, 32'h0, lat, rd, er);
    n_tests++; if (er !== 1'b1) begin n_fail++; $display("FAIL mis_rd_err got=%b exp=1", er); end
    n_tests++; if (rd !== 32'd0) begin n_fail++; $display("FAIL mis_rd_data got=%h exp=0", rd); end
    do_req2(1'b0, 32'h20, 32'h0, lat, rd, er);
    n_tests++; if (rd !== 32'h0BAD_0020) begin n_fail++; $display("FAIL mis_no_corrupt got=%h exp=0bad0020", rd); end
  endtask

  task automatic test_reset_mid();
    int lat; logic [31:0] rd; logic er;
    int spurious = 0;
    do_req2(1'b1, 32'h08, 32'h1111_0008, lat, rd, er);
    @(posedge clk); #1;
    v2 = 1'b1; w2 = 1'b1; a2 = 32'h08; d2 = 32'hCAFE_F00D;
    @(posedge clk); #1;
    v2 = 1'b0;
    n_tests++; if (rdy2 !== 1'b0) begin n_fail++; $display("FAIL wait_ready got=%b exp=0", rdy2); end
    reset = 1'b0;
    @(posedge clk); #1;
    n_tests++; if (rv2 !== 1'b0) begin n_fail++; $display("FAIL mid_reset_valid got=%b exp=0", rv2); end
    n_tests++; if (rdy2 !== 1'b0) begin n_fail++; $display("FAIL mid_reset_ready got=%b exp=0", rdy2); end
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (rv2) spurious++;
    end
    n_tests++; if (rdy2 !== 1'b1) begin n_fail++; $display("FAIL post_reset_ready got=%b exp=1", rdy2); end
    n_tests++; if (spurious != 0) begin n_fail++; $display("FAIL post_reset_pulses got=%0d exp=0", spurious); end
    do_req2(1'b0, 32'h08, 32'h0, lat, rd, er);
    n_tests++; if (rd !== 32'h1111_0008) begin n_fail++; $display("FAIL discard_write got=%h exp=11110008", rd); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_back_to_back();
    test_range();
    test_misaligned();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
